// File: rtl/jtdd_vtimer.sv
// Video timing generator: horizontal/vertical counters, blanking and sync,
// bus phase strobes, line/frame markers and a frame-synchronous screen flip.
// Every output comes from a register loaded with a decode of the next-state
// counter values, so it always matches the current hn/vn.
module jtdd_vtimer #(
   parameter int HW       = 9,
   parameter int VW       = 9,
   parameter int HTOTAL   = 384,
   parameter int HB_START = 256,
   parameter int HS_START = 320,
   parameter int HS_LEN   = 32,
   parameter int VMIN     = 8,
   parameter int VMAX     = 263,
   parameter int VB_START = 248,
   parameter int VB_END   = 16,
   parameter int VS_START = 252,
   parameter int VS_LEN   = 4,
   parameter int PHASES   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pxl_cen,
   input  logic              flip,
   output logic [HW-1:0]     HPOS,
   output logic [VW-1:0]     VPOS,
   output logic              HBL,
   output logic              VBL,
   output logic              HS,
   output logic              VS,
   output logic [PHASES-1:0] PH,
   output logic              LINE,
   output logic              FRAME
);

   localparam int PHW    = $clog2(PHASES);
   localparam int VLINES = VMAX - VMIN + 1;
   // VS end line wraps through VMAX->VMIN when the pulse straddles the frame end
   localparam int VS_END = (VS_START + VS_LEN > VMAX) ? (VS_START + VS_LEN - VLINES)
                                                      : (VS_START + VS_LEN);

   localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
   localparam logic [HW-1:0] HB_C     = HW'(HB_START);
   localparam logic [HW-1:0] HS_C     = HW'(HS_START);
   localparam logic [HW-1:0] HS_LAST  = HW'(HS_START + HS_LEN - 1);
   localparam logic [VW-1:0] V_MIN    = VW'(VMIN);
   localparam logic [VW-1:0] V_LAST   = VW'(VMAX);
   localparam logic [VW-1:0] VB_C     = VW'(VB_START);
   localparam logic [VW-1:0] VBE_C    = VW'(VB_END);
   localparam logic [VW-1:0] VS_C     = VW'(VS_START);
   localparam logic [VW-1:0] VSE_C    = VW'(VS_END);
   localparam logic          VBL_RST  = (VMIN < VB_END) ? 1'b1 : 1'b0;

   // Reject inconsistent timing parameters at elaboration
   if (HB_START >= HTOTAL) begin : g_bad_hb
      $error("jtdd_vtimer: HB_START must be below HTOTAL");
   end
   if (HS_START + HS_LEN > HTOTAL) begin : g_bad_hs
      $error("jtdd_vtimer: HS window exceeds HTOTAL");
   end
   if (!(VMIN < VB_END && VB_END <= VB_START && VB_START <= VMAX)) begin : g_bad_v
      $error("jtdd_vtimer: need VMIN < VB_END <= VB_START <= VMAX");
   end
   if (PHASES < 2 || PHASES > 16 || (PHASES & (PHASES - 1)) != 0) begin : g_bad_ph
      $error("jtdd_vtimer: PHASES must be a power of two in 2..16");
   end
   if ((HTOTAL % (2 * PHASES)) != 0) begin : g_bad_phdiv
      $error("jtdd_vtimer: 2*PHASES must divide HTOTAL");
   end

   logic [HW-1:0]     hn_q, hn_d;
   logic [VW-1:0]     vn_q, vn_d;
   logic              flip_q, flip_d;
   logic              frame_q, frame_d;
   logic              line_q, line_d;
   logic [HW-1:0]     hpos_q, hpos_d;
   logic [VW-1:0]     vpos_q, vpos_d;
   logic              hbl_q, hbl_d;
   logic              vbl_q, vbl_d;
   logic              hs_q, hs_d;
   logic              vs_q, vs_d;
   logic [PHASES-1:0] ph_q, ph_d;
   logic              hwrap_s;
   logic              vwrap_s;

   // Counter advance, frame-start flip sampling and line/frame markers
   always_comb begin
      hwrap_s = (hn_q >= H_LAST);
      vwrap_s = (vn_q >= V_LAST);
      hn_d    = hn_q;
      vn_d    = vn_q;
      flip_d  = flip_q;
      frame_d = frame_q;
      line_d  = 1'b0;
      if (pxl_cen) begin
         if (hwrap_s) begin
            hn_d   = {HW{1'b0}};
            line_d = 1'b1;
            if (vwrap_s) begin
               vn_d    = V_MIN;
               flip_d  = flip;
               frame_d = ~frame_q;
            end else begin
               vn_d = vn_q + VW'(1);
            end
         end else begin
            hn_d = hn_q + HW'(1);
         end
      end else begin
         hn_d = hn_q;
      end
   end

   // Output decode from the next-state counters
   always_comb begin
      hpos_d = hn_d ^ {HW{flip_d}};
      vpos_d = vn_d ^ {VW{flip_d}};
      hbl_d  = (hn_d >= HB_C);
      vbl_d  = (vn_d >= VB_C) || (vn_d < VBE_C);
      hs_d   = (hn_d >= HS_C) && (hn_d <= HS_LAST);
      vs_d   = vs_q;
      if (pxl_cen && (hn_d == HS_C)) begin
         if (vn_d == VS_C) begin
            vs_d = 1'b1;
         end else if (vn_d == VSE_C) begin
            vs_d = 1'b0;
         end else begin
            vs_d = vs_q;
         end
      end else begin
         vs_d = vs_q;
      end
      ph_d = {PHASES{1'b0}};
      if (hn_d[0]) begin
         ph_d[hn_d[PHW:1]] = 1'b1;
      end else begin
         ph_d = {PHASES{1'b0}};
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hn_q    <= {HW{1'b0}};
         vn_q    <= V_MIN;
         flip_q  <= 1'b0;
         frame_q <= 1'b0;
         line_q  <= 1'b0;
         hpos_q  <= {HW{1'b0}};
         vpos_q  <= V_MIN;
         hbl_q   <= 1'b0;
         vbl_q   <= VBL_RST;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         ph_q    <= {PHASES{1'b0}};
      end else begin
         hn_q    <= hn_d;
         vn_q    <= vn_d;
         flip_q  <= flip_d;
         frame_q <= frame_d;
         line_q  <= line_d;
         hpos_q  <= hpos_d;
         vpos_q  <= vpos_d;
         hbl_q   <= hbl_d;
         vbl_q   <= vbl_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         ph_q    <= ph_d;
      end
   end

   assign HPOS  = hpos_q;
   assign VPOS  = vpos_q;
   assign HBL   = hbl_q;
   assign VBL   = vbl_q;
   assign HS    = hs_q;
   assign VS    = vs_q;
   assign PH    = ph_q;
   assign LINE  = line_q;
   assign FRAME = frame_q;

endmodule
